// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART block family
// (RX, TX and the TX arbiter).
//
// Contents:
//   arb_state_t              : TX arbiter FSM state (IDLE, TAG, STREAM)
//   BITS_PER_WORD_DEFAULT    : default byte width on every UART byte stream
package uart_pkg;

  localparam int BITS_PER_WORD_DEFAULT = 8;

  // TAG is only reachable when the arbiter is built with UART_ARB_TAG_EN.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TAG    = 2'd1,
    STREAM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin picker.
//
// Returns the first asserted request at or after ptr, wrapping modulo N_REQ.
//
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  PW     index to start searching from (0..N_REQ-1)
//   gnt   out N_REQ  one-hot winner, all zeros when nothing is requested
//   valid out 1      at least one request is asserted
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [PW:0] sum;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      if (!valid && req[sum[PW-1:0]]) begin
        gnt[sum[PW-1:0]] = 1'b1;
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- round-robin, packet-locked scheduler sharing one UART
// transmitter among N_REQ byte-stream requesters.
//
// Once a requester is granted it owns the transmitter until its last byte is
// accepted or it stalls (s_valid low) long enough for the idle timeout to
// revoke the grant.
//
// Optional feature: define UART_ARB_TAG_EN to emit a one-byte tag (owner
// index, zero-extended) ahead of every granted packet.
//
// Handshake: a beat happens on a rising edge where valid & ready are both
// high. Once valid is raised by a producer it is not withdrawn by this block
// before the beat; ready may go high without valid and never waits on it.
//
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   s_valid    in  N_REQ        per-requester byte valid
//   s_last     in  N_REQ        per-requester last byte of packet
//   s_data     in  N_REQ*BPW    requester i at [i*BPW +: BPW]
//   s_ready    out N_REQ        per-requester accept (only the owner's bit)
//   m_valid    out 1            byte valid to the TX core
//   m_data     out BPW          byte to the TX core
//   m_ready    in  1            TX core accepts a byte
//   grant      out N_REQ        registered one-hot owner, zero when idle
//   busy       out 1            registered, high in any state except IDLE
//   timeout    out 1            registered one-cycle pulse on grant revoke
//   dbg_state  out arb_state_t  current FSM state
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int BITS_PER_WORD = BITS_PER_WORD_DEFAULT,
  parameter int IDLE_TIMEOUT  = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_REQ-1:0]               s_valid,
  input  logic [N_REQ-1:0]               s_last,
  input  logic [N_REQ*BITS_PER_WORD-1:0] s_data,
  output logic [N_REQ-1:0]               s_ready,
  output logic                           m_valid,
  output logic [BITS_PER_WORD-1:0]       m_data,
  input  logic                           m_ready,
  output logic [N_REQ-1:0]               grant,
  output logic                           busy,
  output logic                           timeout,
  output arb_state_t                     dbg_state
);

  localparam int PW = $clog2(N_REQ);
  // A zero timeout still needs a legal one-bit counter.
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;

  arb_state_t             state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   timeout_d;

  logic [N_REQ-1:0]       pick_gnt;
  logic                   pick_valid;

  logic [PW-1:0]          owner_idx;
  logic [PW-1:0]          next_ptr;
  logic [BITS_PER_WORD-1:0] owner_data;
  logic                   owner_valid;
  logic                   owner_last;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req   (s_valid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Decode the one-hot owner into an index plus its stream signals.
  always_comb begin
    owner_idx   = '0;
    owner_data  = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx   = PW'(i);
        owner_data  = s_data[i*BITS_PER_WORD +: BITS_PER_WORD];
        owner_valid = s_valid[i];
        owner_last  = s_last[i];
      end
    end
  end

  // The requester after the current owner gets first claim next time.
  assign next_ptr = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + PW'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    s_ready   = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
          state_d = TAG;
`else
          state_d = STREAM;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      TAG: begin
        // Tag byte comes from the arbiter itself; requesters stay stalled.
        m_valid = 1'b1;
        m_data  = BITS_PER_WORD'(owner_idx);
        if (m_ready) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
`endif

      STREAM: begin
        m_valid = owner_valid;
        m_data  = owner_data;
        s_ready = grant_q & {N_REQ{m_ready}};
        if (owner_valid && m_ready) begin
          // A beat always beats the timeout threshold.
          cnt_d = '0;
          if (owner_last) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end
        end else if (!owner_valid && (IDLE_TIMEOUT != 0)) begin
          // Only stalls with m_valid low count, so a revoke never
          // withdraws a byte that the TX core is looking at.
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            grant_d   = '0;
            rr_ptr_d  = next_ptr;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      busy     <= (state_d != IDLE);
      timeout  <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- directed test of uart_tx_arbiter with N_REQ=4,
// 8-bit bytes and IDLE_TIMEOUT=8. Inputs change 1 time unit after the rising
// edge; outputs are checked 3 units later, well before the next edge.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N_REQ = 4;
  localparam int BPW   = 8;
  localparam int TMO   = 8;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [N_REQ-1:0]     s_valid;
  logic [N_REQ-1:0]     s_last;
  logic [N_REQ*BPW-1:0] s_data;
  logic [N_REQ-1:0]     s_ready;
  logic                 m_valid;
  logic [BPW-1:0]       m_data;
  logic                 m_ready;
  logic [N_REQ-1:0]     grant;
  logic                 busy;
  logic                 timeout;
  arb_state_t           dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [BPW-1:0] exp_q[$];
  logic [BPW-1:0] bp_bytes[4] = '{8'h51, 8'h52, 8'h53, 8'h54};
  int idx;

  uart_tx_arbiter #(
    .N_REQ         (N_REQ),
    .BITS_PER_WORD (BPW),
    .IDLE_TIMEOUT  (TMO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .grant     (grant),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [BPW-1:0] d);
    s_valid[i]          = v;
    s_last[i]           = l;
    s_data[i*BPW +: BPW] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b0;

    // reset state
    #12;
    chk("rst_grant",   32'(grant),   32'h0);
    chk("rst_sready",  32'(s_ready), 32'h0);
    chk("rst_mvalid",  32'(m_valid), 32'h0);
    chk("rst_mdata",   32'(m_data),  32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    tick();
    rstn = 1'b1;
    tick();

`ifdef UART_ARB_TAG_EN
    // tag: req3 sends 0xA5 with last, preceded by tag byte 0x03
    m_ready = 1'b1;
    drive(3, 1'b1, 1'b1, 8'hA5);
    tick(); settle();
    chk("tag_grant",  32'(grant),   32'h8);
    chk("tag_mvalid", 32'(m_valid), 32'h1);
    chk("tag_mdata",  32'(m_data),  32'h03);
    chk("tag_sready", 32'(s_ready), 32'h0);
    tick(); settle();
    chk("tag_byte",   32'(m_data),  32'hA5);
    chk("tag_sready_stream", 32'(s_ready), 32'h8);
    tick(); drive(3, 1'b0, 1'b0, 8'h00); settle();
    chk("tag_end_grant", 32'(grant), 32'h0);
    chk("tag_end_busy",  32'(busy),  32'h0);
`else
    // single requester: req1 sends 0x11,0x22,0x33
    m_ready = 1'b1;
    drive(1, 1'b1, 1'b0, 8'h11);
    settle();
    chk("t1_idle_grant",  32'(grant),   32'h0);
    chk("t1_idle_mvalid", 32'(m_valid), 32'h0);
    tick(); settle();
    chk("t1_grant",  32'(grant),   32'h2);
    chk("t1_busy",   32'(busy),    32'h1);
    chk("t1_sready", 32'(s_ready), 32'h2);
    chk("t1_b0",     32'(m_data),  32'h11);
    tick(); drive(1, 1'b1, 1'b0, 8'h22); settle();
    chk("t1_b1", 32'(m_data), 32'h22);
    tick(); drive(1, 1'b1, 1'b1, 8'h33); settle();
    chk("t1_b2",        32'(m_data),  32'h33);
    chk("t1_b2_mvalid", 32'(m_valid), 32'h1);
    tick(); drive(1, 1'b0, 1'b0, 8'h00); settle();
    chk("t1_end_busy",  32'(busy),  32'h0);
    chk("t1_end_grant", 32'(grant), 32'h0);

    // fairness: all four hold 1-byte packets; rr_ptr=2 after test 1
    for (int i = 0; i < N_REQ; i++) drive(i, 1'b1, 1'b1, 8'(8'hA0 + i));
    for (int k = 0; k < 5; k++) begin
      idx = (2 + k) % N_REQ;
      tick(); settle();
      chk("fair_grant", 32'(grant),  32'(1 << idx));
      chk("fair_data",  32'(m_data), 32'(8'hA0 + idx));
      tick(); settle();
      chk("fair_gap", 32'(grant), 32'h0);
    end
    for (int i = 0; i < N_REQ; i++) drive(i, 1'b0, 1'b0, 8'h00);

    // backpressure: req0 4-byte packet, req1 requesting as non-owner (rr_ptr=3)
    m_ready = 1'b0;
    drive(0, 1'b1, 1'b0, bp_bytes[0]);
    drive(1, 1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 4; i++) exp_q.push_back(bp_bytes[i]);
    tick(); settle();
    chk("bp_grant", 32'(grant), 32'h1);
    idx = 0;
    for (int j = 0; j < 20 && exp_q.size() > 0; j++) begin
      m_ready = (j % 2 == 0);
      drive(0, 1'b1, (idx == 3), bp_bytes[idx]);
      settle();
      chk("bp_data",   32'(m_data),  32'(exp_q[0]));
      chk("bp_sready", 32'(s_ready), m_ready ? 32'h1 : 32'h0);
      if (m_ready) begin
        void'(exp_q.pop_front());
        idx++;
      end
      tick();
    end
    chk("bp_drained", 32'(exp_q.size()), 32'h0);
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    m_ready = 1'b1;
    settle();
    chk("bp_end_grant", 32'(grant), 32'h0);

    // timeout: req2 sends 1 byte without last, then stalls; req3 waits (rr_ptr=1)
    drive(2, 1'b1, 1'b0, 8'h77);
    drive(3, 1'b1, 1'b1, 8'h99);
    tick(); settle();
    chk("to_grant", 32'(grant),  32'h4);
    chk("to_data",  32'(m_data), 32'h77);
    tick(); drive(2, 1'b0, 1'b0, 8'h00); settle();
    chk("to_stall_mvalid", 32'(m_valid), 32'h0);
    for (int k = 1; k < TMO; k++) begin
      tick(); settle();
      chk("to_wait_pulse",  32'(timeout), 32'h0);
      chk("to_wait_grant",  32'(grant),   32'h4);
      chk("to_wait_sready", 32'(s_ready), 32'h4);
    end
    tick(); settle();
    chk("to_pulse",       32'(timeout), 32'h1);
    chk("to_pulse_grant", 32'(grant),   32'h0);
    chk("to_pulse_busy",  32'(busy),    32'h0);
    tick(); settle();
    chk("to_pulse_once", 32'(timeout), 32'h0);
    chk("to_next_grant", 32'(grant),   32'h8);
    chk("to_next_data",  32'(m_data),  32'h99);
    tick(); drive(3, 1'b0, 1'b0, 8'h00); settle();
    chk("to_next_end", 32'(grant), 32'h0);

    // reset mid-packet: req0 (rr_ptr=0)
    drive(0, 1'b1, 1'b0, 8'h01);
    tick(); settle();
    chk("rm_grant", 32'(grant),  32'h1);
    chk("rm_b0",    32'(m_data), 32'h01);
    tick(); drive(0, 1'b1, 1'b0, 8'h02); settle();
    chk("rm_b1", 32'(m_data), 32'h02);
    rstn = 1'b0;
    #1;
    chk("rm_async_mvalid", 32'(m_valid), 32'h0);
    chk("rm_async_grant",  32'(grant),   32'h0);
    chk("rm_async_busy",   32'(busy),    32'h0);
    chk("rm_async_sready", 32'(s_ready), 32'h0);
    chk("rm_async_mdata",  32'(m_data),  32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h42);
    #2 rstn = 1'b1;
    tick(); settle();
    chk("rm_after_grant", 32'(grant), 32'h2);

    // beat on the threshold cycle: owner stalls 7 cycles, then sends
    drive(1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k < TMO; k++) tick();
    settle();
    chk("bt_pre_timeout", 32'(timeout), 32'h0);
    chk("bt_pre_grant",   32'(grant),   32'h2);
    drive(1, 1'b1, 1'b0, 8'h42);
    #1;
    chk("bt_mvalid", 32'(m_valid), 32'h1);
    chk("bt_data",   32'(m_data),  32'h42);
    tick(); drive(1, 1'b1, 1'b1, 8'h43); settle();
    chk("bt_no_timeout", 32'(timeout), 32'h0);
    chk("bt_keep_grant", 32'(grant),   32'h2);
    chk("bt_last_data",  32'(m_data),  32'h43);
    tick(); drive(1, 1'b0, 1'b0, 8'h00); settle();
    chk("bt_end_grant", 32'(grant), 32'h0);
    chk("bt_end_busy",  32'(busy),  32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked scheduler that shares one UART transmitter among N_REQ byte-stream requesters. It sits between several producers (command responders, telemetry, and the echo path of the parity-checking receiver) and the single serial TX core. Once a requester is granted, it owns the transmitter until its last byte is accepted or an idle timeout fires.

## Interface
- N_REQ, 4: number of requesters, 2..8
- BITS_PER_WORD, 8: byte width on both sides
- IDLE_TIMEOUT, 1024: stall cycles in STREAM before the grant is revoked; 0 disables the timeout
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_valid  in  N_REQ  per-requester byte valid
- s_last  in  N_REQ  per-requester last byte of packet, qualified by s_valid
- s_data  in  N_REQ*BITS_PER_WORD  per-requester byte; requester i occupies bits [i*BITS_PER_WORD +: BITS_PER_WORD]
- s_ready  out  N_REQ  per-requester accept
- m_valid  out  1  byte valid to the TX core
- m_data  out  BITS_PER_WORD  byte to the TX core
- m_ready  in  1  TX core accepts a byte (beat = m_valid & m_ready)
- grant  out  N_REQ  one-hot current owner, all zeros when idle
- busy  out  1  high in any state except IDLE
- timeout  out  1  one-cycle pulse when a grant is revoked by the timeout

## Operation
- States: IDLE, TAG (only with the macro), STREAM.
- IDLE: grant=0, s_ready=0, m_valid=0. If any s_valid bit is high, the next edge picks the first requester at or after rr_ptr (wrapping modulo N_REQ), registers it into grant, and moves to TAG or STREAM.
- STREAM: combinational pass-through of the owner g: m_valid=s_valid[g], m_data=s_data[g], s_ready[g]=m_ready, and every other s_ready bit is 0.
- A beat with s_last[g]=1 goes to IDLE and sets rr_ptr=(g+1) mod N_REQ.
- Stall counter: cleared on entry to STREAM and on every beat. It increments on cycles with s_valid[g]=0. Width is $clog2(IDLE_TIMEOUT+1).
- When the counter reaches IDLE_TIMEOUT-1 and no beat occurs that cycle: pulse timeout, go to IDLE, and set rr_ptr=(g+1) mod N_REQ. The partial packet is abandoned. The timeout is never raised while m_valid is high, so it does not violate the TX handshake.
- Boundary conditions:
  - A beat and the timeout threshold in the same cycle: the beat wins and the counter clears.
  - Non-owners that drop s_valid during a packet are ignored.
  - An owner that drops s_valid mid-packet keeps the grant until the timeout.
  - A single-byte packet (s_last on the first beat) is legal.
  - Reset mid-packet: state IDLE, rr_ptr=0, counter=0. The TX core sees m_valid fall asynchronously.

## Timing
- Reset values: grant=0, s_ready=0, m_valid=0, m_data=0, busy=0, timeout=0, rr_ptr=0.
- Request to first possible beat: 1 cycle without the tag (s_valid sampled in IDLE, grant and STREAM on the next edge). With the tag it is 1 cycle plus the tag beat.
- Packet end to next arbitration: the last beat's edge enters IDLE. There is one bubble cycle, then a grant on the following edge. Minimum inter-packet gap is 2 cycles.
- Throughput in STREAM: one byte per cycle while m_ready is high. No buffering; m_data has zero-cycle latency from s_data.
- grant, busy, and timeout are registered. m_valid, m_data, and s_ready are combinational from state, grant, and the inputs.

## Configuration
- UART_ARB_TAG_EN defined:
  - After arbitration the block enters TAG.
  - In TAG it drives m_valid=1, m_data=owner index zero-extended to BITS_PER_WORD, and all s_ready=0.
  - The tag beat moves it to STREAM.
  - The timeout counter is inactive in TAG.
- UART_ARB_TAG_EN undefined: the TAG state and its logic are absent. Arbitration goes straight to STREAM.

## Structure
- A shared package uart_pkg holds the state enum typedef (IDLE, TAG, STREAM) and the default BITS_PER_WORD constant. The RX/TX blocks use the same package.
- One sub-module, rr_pick: combinational round-robin picker with inputs req[N_REQ] and ptr, and outputs a one-hot gnt and a valid flag. It is instanced once. The FSM, counter, and muxing stay in the top.

## Test plan
- Single requester: req1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) with m_ready=1 -> grant=0010 one cycle after s_valid. m_data sequence is 0x11,0x22,0x33 on consecutive cycles. busy falls after the third beat, and rr_ptr becomes 2.
- Fairness: all four requesters hold s_valid continuously and send 1-byte packets -> grant order is 0,1,2,3,0, with a 2-cycle gap between packets.
- Backpressure: m_ready toggles 1,0,1,0 during a 4-byte packet -> each byte is held stable while m_ready=0. There are no duplicates or drops, and non-owners always see s_ready=0.
- Timeout: IDLE_TIMEOUT=8; req2 sends 1 byte without last, then drops s_valid -> timeout pulses exactly 8 cycles after the beat, grant returns to 0, and the next grant goes to req3 if it is requesting.
- Tag (UART_ARB_TAG_EN): req3 sends 0xA5 with last -> m_data sequence is 0x03 then 0xA5, and s_ready[3] is low during the tag beat.
- Reset mid-packet: assert rstn=0 during the second byte of req0's packet -> all outputs are 0 immediately. After release, req1 requesting wins first because rr_ptr=0 and req0 is idle.
